wts_sram_scheduler: RTL and testbench

//  Time-slot sequencer sharing the single wave-table SRAM among NUM_CH channel parts and the CPU port.
//  On each accepted active pulse it runs one frame:
//  - reads each channel's current wave sample into a per-channel sample register;
//  - then serves at most one pending CPU read or write.

---
 rtl/wts_sram_scheduler.sv | 152 +++++++++++++++
 tb/tb_wts_sram_scheduler.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/wts_sram_scheduler.sv
// Time-slot sequencer sharing the wave-table SRAM between NUM_CH channel parts and the CPU.
// Each accepted active pulse runs one frame: all channel reads, then at most one CPU access.
module wts_sram_scheduler #(
    parameter int NUM_CH  = 5,
    parameter int CH_BITS = 3,
    parameter int ADDR_W  = CH_BITS + 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  active,
    input  logic [NUM_CH*7-1:0]   ch_addr,
    output logic [NUM_CH*8-1:0]   sample,
    output logic                  sample_valid,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [7:0]            cpu_wdata,
    output logic                  cpu_ack,
    output logic [7:0]            cpu_rdata,
    output logic [ADDR_W-1:0]     sram_a,
    output logic [7:0]            sram_d,
    output logic                  sram_we,
    input  logic [7:0]            sram_q,
    output logic                  overrun,
    input  logic                  overrun_clear
);

    typedef enum logic [2:0] {
        IDLE,
        CH_ADDR,
        CH_DATA,
        CPU_ADDR,
        CPU_DATA
    } state_t;

    localparam logic [CH_BITS-1:0] LAST_CH = CH_BITS'(NUM_CH - 1);

    state_t             state, state_next;
    logic [CH_BITS-1:0] ch, ch_next, ch_inc;
    logic [6:0]         snap [NUM_CH];
    logic [6:0]         snap_inc;
    logic [ADDR_W-1:0]  a_next;
    logic [7:0]         d_next;
    logic               we_next;
    logic               snap_load;
    logic               capture;
    logic               valid_next;
    logic               ack_next;
    logic               cpu_rd;

    assign ch_inc = ch + CH_BITS'(1);

    always_comb begin
        snap_inc = '0;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            if (ch_inc == CH_BITS'(n)) snap_inc = snap[n];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ch    <= '0;
        end else begin
            state <= state_next;
            ch    <= ch_next;
        end
    end

    // sram_a/sram_d/sram_we are registered from the next-state decode so the
    // address is on the pins during the ADDR slot and sram_q is ready in the DATA slot.
    always_comb begin
        state_next = state;
        ch_next    = ch;
        a_next     = sram_a;
        d_next     = sram_d;
        we_next    = 1'b0;
        snap_load  = 1'b0;
        capture    = 1'b0;
        valid_next = 1'b0;
        ack_next   = 1'b0;
        case (state)
            IDLE: begin
                if (active) begin
                    snap_load  = 1'b1;
                    ch_next    = '0;
                    a_next     = {CH_BITS'(0), ch_addr[6:0]};
                    state_next = CH_ADDR;
                end
            end
            CH_ADDR: state_next = CH_DATA;
            CH_DATA: begin
                capture = 1'b1;
                if (ch != LAST_CH) begin
                    ch_next    = ch_inc;
                    a_next     = {ch_inc, snap_inc};
                    state_next = CH_ADDR;
                end else begin
                    valid_next = 1'b1;
                    if (cpu_req) begin
                        a_next     = cpu_addr;
                        d_next     = cpu_wdata;
                        we_next    = cpu_we;
                        state_next = CPU_ADDR;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            CPU_ADDR: state_next = CPU_DATA;
            CPU_DATA: begin
                ack_next   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sram_a       <= '0;
            sram_d       <= '0;
            sram_we      <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            cpu_ack      <= 1'b0;
            cpu_rdata    <= '0;
            cpu_rd       <= 1'b0;
            overrun      <= 1'b0;
            for (int unsigned n = 0; n < NUM_CH; n++) snap[n] <= '0;
        end else begin
            sram_a       <= a_next;
            sram_d       <= d_next;
            sram_we      <= we_next;
            sample_valid <= valid_next;
            cpu_ack      <= ack_next;
            if (snap_load) begin
                for (int unsigned n = 0; n < NUM_CH; n++) snap[n] <= ch_addr[7*n +: 7];
            end
            if (capture) begin
                for (int unsigned n = 0; n < NUM_CH; n++) begin
                    if (ch == CH_BITS'(n)) sample[8*n +: 8] <= sram_q;
                end
            end
            if (state_next == CPU_ADDR) cpu_rd <= ~cpu_we;
            if (state == CPU_DATA && cpu_rd) cpu_rdata <= sram_q;
            if (active && state != IDLE) overrun <= 1'b1;
            else if (overrun_clear)      overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wts_sram_scheduler.sv
// Bench for wts_sram_scheduler: SRAM model, directed and randomized frames checked
// against a memory-level reference of what each frame should read and write.
module tb_wts_sram_scheduler;

    localparam int NUM_CH  = 5;
    localparam int CH_BITS = 3;
    localparam int ADDR_W  = CH_BITS + 7;
    localparam int VCYC    = 2 * NUM_CH + 1;
    localparam int ACYC    = 2 * NUM_CH + 3;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 active = 1'b0;
    logic [NUM_CH*7-1:0]  ch_addr = '0;
    logic [NUM_CH*8-1:0]  sample;
    logic                 sample_valid;
    logic                 cpu_req = 1'b0;
    logic                 cpu_we = 1'b0;
    logic [ADDR_W-1:0]    cpu_addr = '0;
    logic [7:0]           cpu_wdata = '0;
    logic                 cpu_ack;
    logic [7:0]           cpu_rdata;
    logic [ADDR_W-1:0]    sram_a;
    logic [7:0]           sram_d;
    logic                 sram_we;
    logic [7:0]           sram_q;
    logic                 overrun;
    logic                 overrun_clear = 1'b0;

    logic                 preload = 1'b1;
    logic [7:0]           mem     [0:(1<<ADDR_W)-1];
    logic [7:0]           ref_mem [0:(1<<ADDR_W)-1];

    int checks = 0;
    int errors = 0;

    wts_sram_scheduler #(.NUM_CH(NUM_CH), .CH_BITS(CH_BITS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .active(active), .ch_addr(ch_addr),
        .sample(sample), .sample_valid(sample_valid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .sram_a(sram_a), .sram_d(sram_d), .sram_we(sram_we), .sram_q(sram_q),
        .overrun(overrun), .overrun_clear(overrun_clear)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM: data for an address appears the cycle after it is presented.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= 8'(i);
        end else begin
            if (sram_we) mem[sram_a] <= sram_d;
            sram_q <= mem[sram_a];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM_CH*8-1:0] exp_samples(input logic [NUM_CH*7-1:0] ca);
        logic [NUM_CH*8-1:0] s;
        s = '0;
        for (int n = 0; n < NUM_CH; n++) s[8*n +: 8] = ref_mem[n * 128 + int'(ca[7*n +: 7])];
        return s;
    endfunction

    // Pulses active, then watches 20 cycles; cycle c is the one after the c-th edge.
    task automatic frame(input int scr_at, input int act2_at, input int clr_at,
                         output int vcyc, output int vcnt, output int acyc, output int wecnt);
        vcyc = -1; vcnt = 0; acyc = -1; wecnt = 0;
        active = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            active = 1'b0;
            overrun_clear = 1'b0;
            if (sample_valid) begin vcnt++; vcyc = c; end
            if (sram_we) wecnt++;
            if (cpu_ack) begin acyc = c; cpu_req = 1'b0; end
            if (c == scr_at) ch_addr = (NUM_CH*7)'({$urandom(), $urandom()});
            if (c == act2_at) active = 1'b1;
            if (c == clr_at) overrun_clear = 1'b1;
        end
    endtask

    initial begin
        int vcyc, vcnt, acyc, wecnt;
        logic [NUM_CH*7-1:0] ca;
        logic [NUM_CH*8-1:0] es;
        logic [7:0] exp_rdata;
        logic [ADDR_W-1:0] last_a;
        logic do_req, do_we;

        for (int i = 0; i < (1 << ADDR_W); i++) ref_mem[i] = 8'(i);
        repeat (3) @(posedge clk);
        #1;
        preload = 1'b0;
        chk("reset_sample", 64'(sample), 64'(0));
        chk("reset_valid", 64'(sample_valid), 64'(0));
        chk("reset_ack", 64'(cpu_ack), 64'(0));
        chk("reset_sram_a", 64'(sram_a), 64'(0));
        chk("reset_sram_we", 64'(sram_we), 64'(0));
        chk("reset_overrun", 64'(overrun), 64'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        // Channel read with the 7'h10+n pattern
        for (int n = 0; n < NUM_CH; n++) ch_addr[7*n +: 7] = 7'(8'h10 + n);
        frame(-1, -1, -1, vcyc, vcnt, acyc, wecnt);
        chk("pattern_sample", 64'(sample), 64'({8'h14, 8'h93, 8'h12, 8'h91, 8'h10}));
        chk("pattern_vcyc", 64'(vcyc), 64'(VCYC));
        chk("pattern_vcnt", 64'(vcnt), 64'(1));
        chk("pattern_we", 64'(wecnt), 64'(0));
        chk("noreq_ack", 64'(acyc), 64'(-1));
        chk("noreq_sram_a", 64'(sram_a), 64'({3'd4, 7'h14}));

        // CPU write 8'hA5 to 10'h085, then read it back
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h085; cpu_wdata = 8'hA5;
        frame(-1, -1, -1, vcyc, vcnt, acyc, wecnt);
        ref_mem[10'h085] = 8'hA5;
        chk("wr_ack", 64'(acyc), 64'(ACYC));
        chk("wr_we", 64'(wecnt), 64'(1));
        chk("wr_mem", 64'(mem[10'h085]), 64'(8'hA5));
        cpu_req = 1'b1; cpu_we = 1'b0;
        frame(-1, -1, -1, vcyc, vcnt, acyc, wecnt);
        chk("rd_ack", 64'(acyc), 64'(ACYC));
        chk("rd_we", 64'(wecnt), 64'(0));
        chk("rd_data", 64'(cpu_rdata), 64'(8'hA5));
        exp_rdata = 8'hA5;

        // Randomized frames, with ch_addr sometimes changed mid-frame
        for (int k = 0; k < 16; k++) begin
            ca = (NUM_CH*7)'({$urandom(), $urandom()});
            ch_addr = ca;
            do_req = 1'($urandom_range(0, 1));
            do_we  = 1'($urandom_range(0, 1));
            cpu_req = do_req; cpu_we = do_we;
            cpu_addr = ADDR_W'($urandom()); cpu_wdata = 8'($urandom());
            es = exp_samples(ca);
            last_a = {3'd4, ca[7*(NUM_CH-1) +: 7]};
            frame(k % 3 == 0 ? 3 : -1, -1, -1, vcyc, vcnt, acyc, wecnt);
            if (do_req && !do_we) exp_rdata = ref_mem[cpu_addr];
            if (do_req && do_we) ref_mem[cpu_addr] = cpu_wdata;
            if (do_req) last_a = cpu_addr;
            chk("rnd_sample", 64'(sample), 64'(es));
            chk("rnd_vcyc", 64'(vcyc), 64'(VCYC));
            chk("rnd_ack", 64'(acyc), do_req ? 64'(ACYC) : 64'(-1));
            chk("rnd_we", 64'(wecnt), 64'(do_req && do_we));
            chk("rnd_rdata", 64'(cpu_rdata), 64'(exp_rdata));
            chk("rnd_sram_a", 64'(sram_a), 64'(last_a));
            chk("rnd_overrun", 64'(overrun), 64'(0));
        end

        // Overrun: second pulse 3 cycles later is ignored
        cpu_req = 1'b0;
        ca = (NUM_CH*7)'({$urandom(), $urandom()});
        ch_addr = ca;
        es = exp_samples(ca);
        frame(3, 3, -1, vcyc, vcnt, acyc, wecnt);
        chk("ovr_flag", 64'(overrun), 64'(1));
        chk("ovr_vcnt", 64'(vcnt), 64'(1));
        chk("ovr_sample", 64'(sample), 64'(es));
        frame(-1, 5, 5, vcyc, vcnt, acyc, wecnt);
        chk("ovr_set_wins", 64'(overrun), 64'(1));
        overrun_clear = 1'b1;
        @(posedge clk); #1;
        overrun_clear = 1'b0;
        chk("ovr_clear", 64'(overrun), 64'(0));

        // Reset during CH_DATA of channel 2 with a read request held
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h085;
        active = 1'b1;
        @(posedge clk); #1;
        active = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_sample", 64'(sample), 64'(0));
        chk("rst_rdata", 64'(cpu_rdata), 64'(0));
        chk("rst_sram_a", 64'(sram_a), 64'(0));
        chk("rst_outs", 64'({sample_valid, cpu_ack, sram_we, overrun, sram_d}), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        ca = (NUM_CH*7)'({$urandom(), $urandom()});
        ch_addr = ca;
        es = exp_samples(ca);
        frame(-1, -1, -1, vcyc, vcnt, acyc, wecnt);
        chk("post_rst_sample", 64'(sample), 64'(es));
        chk("post_rst_ack", 64'(acyc), 64'(ACYC));
        chk("post_rst_rdata", 64'(cpu_rdata), 64'(8'hA5));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
